// File: rtl/aes_tx_ser.sv
// Serialises words from a show-ahead FIFO into LANE_W-wide beats, one word per BEATS cycles.
// Define AES_TX_SER_PARITY_EN to add the tx_par output (even parity of tx).
module aes_tx_ser #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned LANE_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] data,
    input  logic              empty,
    output logic              require,
    input  logic              stall,
    input  logic              msb_first,
    output logic [LANE_W-1:0] tx,
    output logic              tx_valid,
    output logic              shakehand
`ifdef AES_TX_SER_PARITY_EN
    ,
    output logic              tx_par
`endif
);

    localparam int unsigned BEATS  = WORD_W / LANE_W;
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              order_q, order_d;
    logic              require_q, require_d;
    logic              capture;
    logic [BEAT_W-1:0] lane_idx;

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        word_d    = word_q;
        order_d   = order_q;
        require_d = 1'b0;
        capture   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) capture = 1'b1;
            end
            SEND: begin
                if (!stall) begin
                    if (beat_q != LAST_BEAT) begin
                        beat_d = beat_q + BEAT_W'(1);
                    end else if (!empty) begin
                        capture = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // A capture also pops the FIFO one cycle later via the registered strobe.
        if (capture) begin
            word_d    = data;
            order_d   = msb_first;
            beat_d    = '0;
            state_d   = SEND;
            require_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            word_q    <= '0;
            order_q   <= 1'b0;
            require_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            word_q    <= word_d;
            order_q   <= order_d;
            require_q <= require_d;
        end
    end

    assign lane_idx = order_q ? (LAST_BEAT - beat_q) : beat_q;

    always_comb begin
        tx = '0;
        for (int i = 0; i < BEATS; i++) begin
            if (state_q == SEND && lane_idx == BEAT_W'(i)) begin
                tx = word_q[i*LANE_W +: LANE_W];
            end
        end
    end

    assign require   = require_q;
    assign tx_valid  = (state_q == SEND);
    assign shakehand = (state_q == SEND) && (beat_q == '0);

`ifdef AES_TX_SER_PARITY_EN
    assign tx_par = ^tx;
`endif

endmodule

// File: tb/tb_aes_tx_ser.sv
// Scoreboard bench for aes_tx_ser: default 32/8 instance plus a 64/16 instance.
module tb_aes_tx_ser;

    typedef struct {
        logic [15:0] tx;
        logic        sh;
        logic        req;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        msb_first = 1'b1;

    logic [31:0] data0 = '0;
    logic        empty0 = 1'b1;
    logic        require0, tx_valid0, shakehand0;
    logic [7:0]  tx0;
    logic [63:0] data1 = '0;
    logic        empty1 = 1'b1;
    logic        require1, tx_valid1, shakehand1;
    logic [15:0] tx1;
`ifdef AES_TX_SER_PARITY_EN
    logic        tx_par0, tx_par1;
`endif

    logic [31:0] fifo0[$];
    logic [63:0] fifo1[$];
    beat_t       exp0[$];
    beat_t       exp1[$];
    logic        pend0 = 1'b0;
    logic        pend1 = 1'b0;
    logic        mon_en = 1'b0;
    int          n_cmp = 0;
    int          n_fail = 0;
    int          run0 = 0;
    int          max0 = 0;
    int          reqcnt0 = 0;

    always #5 clk = ~clk;

    aes_tx_ser dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .data      (data0),
        .empty     (empty0),
        .require   (require0),
        .stall     (stall),
        .msb_first (msb_first),
        .tx        (tx0),
        .tx_valid  (tx_valid0),
        .shakehand (shakehand0)
`ifdef AES_TX_SER_PARITY_EN
        ,
        .tx_par    (tx_par0)
`endif
    );

    aes_tx_ser #(.WORD_W(64), .LANE_W(16)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .data      (data1),
        .empty     (empty1),
        .require   (require1),
        .stall     (1'b0),
        .msb_first (msb_first),
        .tx        (tx1),
        .tx_valid  (tx_valid1),
        .shakehand (shakehand1)
`ifdef AES_TX_SER_PARITY_EN
        ,
        .tx_par    (tx_par1)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic refresh();
        empty0 = (fifo0.size() == 0);
        data0  = empty0 ? 32'h0 : fifo0[0];
        empty1 = (fifo1.size() == 0);
        data1  = empty1 ? 64'h0 : fifo1[0];
    endtask

    // FIFO pops take effect at the edge that ends the cycle in which require was high.
    task automatic tick();
        @(posedge clk);
        #1;
        if (pend0 && fifo0.size() > 0) void'(fifo0.pop_front());
        if (pend1 && fifo1.size() > 0) void'(fifo1.pop_front());
        pend0 = require0;
        pend1 = require1;
        refresh();
    endtask

    task automatic e0(input logic [15:0] t, input logic s, input logic r);
        beat_t e;
        e.tx = t; e.sh = s; e.req = r;
        exp0.push_back(e);
    endtask

    task automatic e1(input logic [15:0] t, input logic s, input logic r);
        beat_t e;
        e.tx = t; e.sh = s; e.req = r;
        exp1.push_back(e);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (tx_valid0) begin
                if (exp0.size() == 0) begin
                    chk("d0 unexpected beat", 32'(tx0), 32'hFFFF_FFFF);
                end else begin
                    beat_t e;
                    e = exp0.pop_front();
                    chk("d0 tx", 32'(tx0), 32'(e.tx));
                    chk("d0 shakehand", 32'(shakehand0), 32'(e.sh));
                    chk("d0 require", 32'(require0), 32'(e.req));
`ifdef AES_TX_SER_PARITY_EN
                    chk("d0 tx_par", 32'(tx_par0), 32'(^e.tx));
`endif
                end
                run0++;
            end else begin
                chk("d0 idle tx/sh/req", {22'h0, tx0, shakehand0, require0}, 32'h0);
`ifdef AES_TX_SER_PARITY_EN
                chk("d0 idle tx_par", 32'(tx_par0), 32'h0);
`endif
                if (run0 > max0) max0 = run0;
                run0 = 0;
            end
            if (require0) reqcnt0++;

            if (tx_valid1) begin
                if (exp1.size() == 0) begin
                    chk("d1 unexpected beat", 32'(tx1), 32'hFFFF_FFFF);
                end else begin
                    beat_t e;
                    e = exp1.pop_front();
                    chk("d1 tx", 32'(tx1), 32'(e.tx));
                    chk("d1 shakehand", 32'(shakehand1), 32'(e.sh));
                    chk("d1 require", 32'(require1), 32'(e.req));
`ifdef AES_TX_SER_PARITY_EN
                    chk("d1 tx_par", 32'(tx_par1), 32'(^e.tx));
`endif
                end
            end else begin
                chk("d1 idle tx/sh/req", {14'h0, tx1, shakehand1, require1}, 32'h0);
            end
        end
    end

    initial begin
        refresh();
        repeat (3) tick();
        mon_en = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();

        // msb-first single word
        msb_first = 1'b1;
        e0(16'h11, 1, 1); e0(16'h22, 0, 0); e0(16'h33, 0, 0); e0(16'h44, 0, 0);
        fifo0.push_back(32'h1122_3344); refresh();
        repeat (8) tick();

        // lsb-first, order input toggled mid-word
        msb_first = 1'b0;
        e0(16'hD4, 1, 1); e0(16'hC3, 0, 0); e0(16'hB2, 0, 0); e0(16'hA1, 0, 0);
        fifo0.push_back(32'hA1B2_C3D4); refresh();
        repeat (3) tick();
        msb_first = 1'b1;
        repeat (6) tick();

        // three words back-to-back
        max0 = 0; reqcnt0 = 0;
        e0(16'hAA, 1, 1); e0(16'hBB, 0, 0); e0(16'hCC, 0, 0); e0(16'hDD, 0, 0);
        e0(16'h10, 1, 1); e0(16'h20, 0, 0); e0(16'h30, 0, 0); e0(16'h40, 0, 0);
        e0(16'h0F, 1, 1); e0(16'h0E, 0, 0); e0(16'h0D, 0, 0); e0(16'h0C, 0, 0);
        fifo0.push_back(32'hAABB_CCDD);
        fifo0.push_back(32'h1020_3040);
        fifo0.push_back(32'h0F0E_0D0C);
        refresh();
        repeat (16) tick();
        chk("b2b contiguous beats", 32'(max0), 32'd12);
        chk("b2b require pulses", 32'(reqcnt0), 32'd3);

        // stall for 3 cycles at beat 1
        max0 = 0;
        e0(16'h01, 1, 1); e0(16'h02, 0, 0); e0(16'h02, 0, 0); e0(16'h02, 0, 0);
        e0(16'h02, 0, 0); e0(16'h03, 0, 0); e0(16'h04, 0, 0);
        fifo0.push_back(32'h0102_0304); refresh();
        repeat (2) tick();
        stall = 1'b1;
        repeat (3) tick();
        stall = 1'b0;
        repeat (6) tick();
        chk("stall word length", 32'(max0), 32'd7);

        // reset at beat 2, then a fresh word
        e0(16'h55, 1, 1); e0(16'h66, 0, 0); e0(16'h77, 0, 0);
        fifo0.push_back(32'h5566_7788); refresh();
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        e0(16'hCA, 1, 1); e0(16'hFE, 0, 0); e0(16'hF0, 0, 0); e0(16'h0D, 0, 0);
        fifo0.push_back(32'hCAFE_F00D); refresh();
        repeat (8) tick();

        // wide instance
        msb_first = 1'b1;
        e1(16'h0001, 1, 1); e1(16'h0003, 0, 0); e1(16'h0007, 0, 0); e1(16'h0000, 0, 0);
        fifo1.push_back(64'h0001_0003_0007_0000); refresh();
        repeat (8) tick();

        for (int i = 0; i < 20 && (exp0.size() != 0 || exp1.size() != 0); i++) tick();
        chk("d0 drained", 32'(exp0.size()), 32'd0);
        chk("d1 drained", 32'(exp1.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_tx_ser.md
AES_TX_SER -- requirements
Module: aes_tx_ser

Interface
REQ-001 Parameter WORD_W, default 32, SHALL set the width of the input word taken from the FIFO.
REQ-002 Parameter LANE_W, default 8, SHALL set the width of one output beat; WORD_W SHALL be an integer multiple of LANE_W, with BEATS = WORD_W/LANE_W >= 2.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 data  input  WORD_W  SHALL carry the head word of a show-ahead FIFO, valid whenever empty=0.
REQ-006 empty  input  1  SHALL indicate, when high, that the FIFO has no word.
REQ-007 require  output  1  SHALL be a one-cycle pop strobe to the FIFO.
REQ-008 stall  input  1  SHALL indicate, when high, that downstream refuses the current beat.
REQ-009 msb_first  input  1  SHALL select the beat order: 1 = most-significant lane first, 0 = least-significant lane first.
REQ-010 tx  output  LANE_W  SHALL carry the current beat.
REQ-011 tx_valid  output  1  SHALL be high while tx holds a valid beat.
REQ-012 shakehand  output  1  SHALL be high on the first beat of each word (frame marker).

Function
REQ-013 The block SHALL have two states: IDLE and SEND, plus a beat counter beat in the range 0..BEATS-1 and a word register word_q.
REQ-014 In IDLE with empty=0, the block SHALL capture data into word_q and msb_first into an order register, set beat=0, and enter SEND at that edge.
REQ-015 In IDLE with empty=1, the block SHALL stay in IDLE; stall SHALL be ignored in IDLE.
REQ-016 require SHALL be registered and high for exactly the one cycle following each capture edge; it SHALL never be high in two consecutive cycles.
REQ-017 In SEND with stall=1, beat, word_q, state, tx, tx_valid and shakehand SHALL all hold.
REQ-018 In SEND with stall=0 and beat<BEATS-1, beat SHALL increment by 1.
REQ-019 In SEND with stall=0, beat=BEATS-1 and empty=0, the block SHALL capture the next word, set beat=0 and stay in SEND, with no idle cycle between words.
REQ-020 In SEND with stall=0, beat=BEATS-1 and empty=1, the block SHALL return to IDLE.
REQ-021 tx SHALL be word_q[LANE_W*(BEATS-1-beat) +: LANE_W] when the captured order is 1, and word_q[LANE_W*beat +: LANE_W] otherwise; tx SHALL be 0 in IDLE.
REQ-022 tx_valid SHALL be 1 exactly when the state is SEND.
REQ-023 shakehand SHALL be 1 exactly when the state is SEND and beat=0.
REQ-024 Changes to msb_first or data in the middle of a word SHALL NOT affect that word.
REQ-025 Latency SHALL be one cycle: a word present at a capture edge appears as beat 0 on tx in the cycle that follows.
REQ-026 A word SHALL occupy exactly BEATS cycles on tx, plus one extra cycle for each cycle of stall.

Reset
REQ-027 When rst_n=0 at a rising edge, the block SHALL enter IDLE and clear beat, word_q, the order register, require, tx, tx_valid, shakehand and tx_par.
REQ-028 A reset in the middle of a word SHALL discard the remaining beats without issuing a pop; after reset, capture SHALL resume per REQ-014.

Configuration
REQ-029 When macro AES_TX_SER_PARITY_EN is defined, the block SHALL have an extra output tx_par, width 1, equal to the even parity (XOR reduction) of tx, held during stall and 0 in IDLE.
REQ-030 When AES_TX_SER_PARITY_EN is not defined, tx_par SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-031 Default parameters, msb_first=1, a single word 0x11223344, stall=0 -> require pulses in the cycle after capture; tx = 11,22,33,44 on 4 consecutive cycles; shakehand high on beat 11 only; then IDLE.
REQ-032 msb_first=0, word 0xA1B2C3D4 -> tx = D4,C3,B2,A1; msb_first toggled at beat 2 -> no change to the order.
REQ-033 Three words queued back-to-back -> 12 contiguous valid beats; exactly 3 require pulses, each one cycle wide.
REQ-034 stall held high for 3 cycles at beat 1 of 0x01020304 -> tx=02 for 4 cycles, then 03,04; word length 7 cycles.
REQ-035 rst_n low at beat 2 -> the next cycle has tx_valid=0, tx=0, require=0; the next word starts from beat 0.
REQ-036 WORD_W=64, LANE_W=16, AES_TX_SER_PARITY_EN defined, word 0x0001000300070000 -> tx = 0001,0003,0007,0000 with tx_par = 1,0,1,0.
